// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 4:1 mux: steps sel 0..3, samples f_in after DWELL cycles per channel,
// and hands the 4-bit word downstream over valid/ready. Optional `parity` output via MUX_SCAN_PARITY_EN.
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       f_in,
  output logic [1:0] sel,
  output logic [3:0] sample,
  output logic       valid,
  input  logic       ready,
  output logic       busy
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [2:0] buf_r, buf_s;
  logic       cont_r, cont_s;
  logic [1:0] sel_s;
  logic [3:0] sample_s;
  logic       valid_s;
  logic       busy_s;

`ifdef MUX_SCAN_PARITY_EN
  function automatic logic parity_of(input logic [3:0] word);
    return ^word;
  endfunction
`endif

  // Next-state and next-output computation for the scan FSM
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    buf_s    = buf_r;
    cont_s   = cont_r;
    sel_s    = sel;
    sample_s = sample;
    valid_s  = valid;
    case (state_r)
      IDLE: begin
        sel_s = 2'd0;
        cnt_s = 8'd0;
        if (start) begin
          state_s = SCAN;
          cont_s  = cont;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (cnt_r == DWELL_LAST) begin
          cnt_s = 8'd0;
          if (sel == 2'd3) begin
            // Last channel goes straight into the word, bypassing the buffer
            sample_s = {f_in, buf_r};
            valid_s  = 1'b1;
            sel_s    = 2'd0;
            state_s  = OUT;
          end else begin
            case (sel)
              2'd0:    buf_s[0] = f_in;
              2'd1:    buf_s[1] = f_in;
              default: buf_s[2] = f_in;
            endcase
            sel_s = sel + 2'd1;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      OUT: begin
        sel_s = 2'd0;
        if (valid && ready) begin
          valid_s = 1'b0;
          cnt_s   = 8'd0;
          state_s = cont_r ? SCAN : IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
        sel_s   = 2'd0;
        cnt_s   = 8'd0;
        valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      buf_r   <= 3'd0;
      cont_r  <= 1'b0;
      sel     <= 2'd0;
      sample  <= 4'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      buf_r   <= buf_s;
      cont_r  <= cont_s;
      sel     <= sel_s;
      sample  <= sample_s;
      valid   <= valid_s;
      busy    <= busy_s;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // Parity tracks the sample register edge for edge
  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else begin
      parity <= parity_of(sample_s);
    end
  end
`endif

endmodule
